// File: rtl/esn_pll_reset_seq_if.sv
// Signal bundle between the PLL/ESN environment and the reset sequencer.
// The sequencer connects through the slave modport; the environment drives the master side.
interface esn_pll_reset_seq_if #(
    parameter int CNT_W = 8
);
    logic             pll_locked;
    logic             sw_rst_req;
    logic             esn_rst_n;
    logic             lock_sync;
    logic             in_run;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] loss_count;

    modport master (
        output pll_locked,
        output sw_rst_req,
        input  esn_rst_n,
        input  lock_sync,
        input  in_run,
        input  state_o,
        input  loss_count
    );

    modport slave (
        input  pll_locked,
        input  sw_rst_req,
        output esn_rst_n,
        output lock_sync,
        output in_run,
        output state_o,
        output loss_count
    );
endinterface

// File: rtl/esn_pll_reset_seq.sv
// Holds the ESN core in reset until the synchronised PLL lock has been stable long enough,
// re-asserts it for a minimum time on lock loss or software request, and counts lock losses.
module esn_pll_reset_seq #(
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int CNT_W         = 8
) (
    input  logic                clock_50,
    input  logic                reset_n,
    esn_pll_reset_seq_if.slave  bus
);
    localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        HOLD      = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             sync1_q, sync1_d;
    logic             lock_sync_q, lock_sync_d;
    logic             esn_rst_n_q, esn_rst_n_d;

    always_comb begin
        sync1_d     = bus.pll_locked;
        lock_sync_d = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        loss_d      = loss_q;

        unique case (state_q)
            IDLE: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_sync_q) state_d = STABLE;
            end
            STABLE: begin
                // Any dropout restarts qualification from scratch.
                if (!lock_sync_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_sync_q) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    if (loss_q != '1) loss_d = loss_q + 1'b1;
                end else if (bus.sw_rst_req) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Reset output follows the next state so it flips on the same edge as the state register.
        esn_rst_n_d = (state_d == RUN);
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b0;
            lock_sync_q <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            loss_q      <= '0;
            esn_rst_n_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            lock_sync_q <= lock_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            esn_rst_n_q <= esn_rst_n_d;
        end
    end

    assign bus.esn_rst_n  = esn_rst_n_q;
    assign bus.in_run     = esn_rst_n_q;
    assign bus.lock_sync  = lock_sync_q;
    assign bus.state_o    = state_q;
    assign bus.loss_count = loss_q;
endmodule

// File: tb/tb_esn_pll_reset_seq.sv
// Directed bench for esn_pll_reset_seq with STABLE_CYCLES=8, HOLD_CYCLES=4, CNT_W=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_esn_pll_reset_seq;
    localparam int STABLE_CYCLES = 8;
    localparam int HOLD_CYCLES   = 4;
    localparam int CNT_W         = 4;

    logic clock_50;
    logic reset_n;
    int   checks;
    int   errors;

    esn_pll_reset_seq_if #(.CNT_W(CNT_W)) bus ();

    esn_pll_reset_seq #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clock_50 (clock_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock_50);
        @(negedge clock_50);
    endtask

    // Returns the edge index (counted from 'start') at which esn_rst_n is first seen high, or -1.
    task automatic wait_release(input int start, output int idx);
        idx = -1;
        for (int k = start; k < start + 64; k++) begin
            step();
            if (bus.esn_rst_n === 1'b1) begin
                idx = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int idx;
        reset_n = 1'b0;
        bus.pll_locked = 1'b1;
        bus.sw_rst_req = 1'b0;
        repeat (3) step();
        checks++;
        if (bus.esn_rst_n !== 1'b0 || bus.in_run !== 1'b0 || bus.lock_sync !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: esn_rst_n=%b in_run=%b lock_sync=%b expected 0 0 0",
                     bus.esn_rst_n, bus.in_run, bus.lock_sync);
        end
        checks++;
        if (bus.state_o !== 3'd0 || bus.loss_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: state_o=%0d loss_count=%0d expected 0 0", bus.state_o, bus.loss_count);
        end
        reset_n = 1'b1;
        wait_release(0, idx);
        checks++;
        if (idx !== 10) begin
            errors++;
            $display("FAIL first_release: edge=%0d expected 10", idx);
        end
        checks++;
        if (bus.state_o !== 3'd3 || bus.in_run !== 1'b1 || bus.lock_sync !== 1'b1) begin
            errors++;
            $display("FAIL run_outputs: state_o=%0d in_run=%b lock_sync=%b expected 3 1 1",
                     bus.state_o, bus.in_run, bus.lock_sync);
        end
        $display("test_reset: release edge %0d state_o %0d", idx, bus.state_o);
    endtask

    task automatic test_stable_glitch();
        int idx;
        reset_n = 1'b0;
        bus.pll_locked = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        bus.pll_locked = 1'b1;
        repeat (6) step();
        bus.pll_locked = 1'b0;
        step();
        bus.pll_locked = 1'b1;
        step();
        checks++;
        if (bus.state_o !== 3'd2) begin
            errors++;
            $display("FAIL glitch_pre: state_o=%0d expected 2", bus.state_o);
        end
        step();
        checks++;
        if (bus.state_o !== 3'd1 || bus.esn_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL glitch_restart: state_o=%0d esn_rst_n=%b expected 1 0", bus.state_o, bus.esn_rst_n);
        end
        wait_release(2, idx);
        checks++;
        if (idx !== 10) begin
            errors++;
            $display("FAIL glitch_release: edge=%0d expected 10", idx);
        end
        checks++;
        if (bus.loss_count !== 4'd0) begin
            errors++;
            $display("FAIL glitch_loss: loss_count=%0d expected 0", bus.loss_count);
        end
        $display("test_stable_glitch: release edge %0d loss_count %0d", idx, bus.loss_count);
    endtask

    task automatic test_run_loss();
        int idx;
        bus.pll_locked = 1'b0;
        step();
        step();
        checks++;
        if (bus.esn_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL loss_latency: esn_rst_n=%b after E1 expected 1", bus.esn_rst_n);
        end
        step();
        checks++;
        if (bus.esn_rst_n !== 1'b0 || bus.state_o !== 3'd4 || bus.loss_count !== 4'd1) begin
            errors++;
            $display("FAIL loss_enter: esn_rst_n=%b state_o=%0d loss_count=%0d expected 0 4 1",
                     bus.esn_rst_n, bus.state_o, bus.loss_count);
        end
        bus.pll_locked = 1'b1;
        for (int h = 1; h < HOLD_CYCLES; h++) begin
            step();
            checks++;
            if (bus.state_o !== 3'd4) begin
                errors++;
                $display("FAIL hold_len: cycle %0d state_o=%0d expected 4", h, bus.state_o);
            end
        end
        step();
        checks++;
        if (bus.state_o !== 3'd1) begin
            errors++;
            $display("FAIL hold_exit: state_o=%0d expected 1", bus.state_o);
        end
        wait_release(5, idx);
        checks++;
        if (idx !== 13) begin
            errors++;
            $display("FAIL loss_rerelease: edge=%0d expected 13", idx);
        end
        $display("test_run_loss: re-release edge %0d loss_count %0d", idx, bus.loss_count);
    endtask

    task automatic test_sw_rst();
        int idx;
        bus.sw_rst_req = 1'b1;
        step();
        bus.sw_rst_req = 1'b0;
        checks++;
        if (bus.state_o !== 3'd4 || bus.esn_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL sw_enter: state_o=%0d esn_rst_n=%b expected 4 0", bus.state_o, bus.esn_rst_n);
        end
        step();
        bus.sw_rst_req = 1'b1;
        step();
        bus.sw_rst_req = 1'b0;
        checks++;
        if (bus.state_o !== 3'd4) begin
            errors++;
            $display("FAIL sw_in_hold: state_o=%0d expected 4", bus.state_o);
        end
        step();
        step();
        checks++;
        if (bus.state_o !== 3'd1) begin
            errors++;
            $display("FAIL sw_hold_exit: state_o=%0d expected 1", bus.state_o);
        end
        step();
        bus.sw_rst_req = 1'b1;
        step();
        bus.sw_rst_req = 1'b0;
        checks++;
        if (bus.state_o !== 3'd2 || bus.esn_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL sw_in_stable: state_o=%0d esn_rst_n=%b expected 2 0", bus.state_o, bus.esn_rst_n);
        end
        wait_release(7, idx);
        checks++;
        if (idx !== 13) begin
            errors++;
            $display("FAIL sw_release: edge=%0d expected 13", idx);
        end
        checks++;
        if (bus.loss_count !== 4'd1) begin
            errors++;
            $display("FAIL sw_loss: loss_count=%0d expected 1", bus.loss_count);
        end
        // Lock loss and software request on the same cycle count as a lock loss.
        bus.pll_locked = 1'b0;
        step();
        step();
        bus.sw_rst_req = 1'b1;
        step();
        bus.sw_rst_req = 1'b0;
        checks++;
        if (bus.state_o !== 3'd4 || bus.loss_count !== 4'd2) begin
            errors++;
            $display("FAIL sw_and_loss: state_o=%0d loss_count=%0d expected 4 2", bus.state_o, bus.loss_count);
        end
        bus.pll_locked = 1'b1;
        wait_release(1, idx);
        checks++;
        if (idx !== 13) begin
            errors++;
            $display("FAIL sw_and_loss_release: edge=%0d expected 13", idx);
        end
        $display("test_sw_rst: loss_count %0d", bus.loss_count);
    endtask

    task automatic test_saturation();
        int idx;
        int exp_loss;
        reset_n = 1'b0;
        bus.pll_locked = 1'b1;
        step();
        reset_n = 1'b1;
        wait_release(0, idx);
        checks++;
        if (idx !== 10 || bus.loss_count !== 4'd0) begin
            errors++;
            $display("FAIL sat_start: edge=%0d loss_count=%0d expected 10 0", idx, bus.loss_count);
        end
        exp_loss = 0;
        for (int i = 0; i < 17; i++) begin
            bus.pll_locked = 1'b0;
            repeat (3) step();
            bus.pll_locked = 1'b1;
            exp_loss = (exp_loss == 15) ? 15 : exp_loss + 1;
            checks++;
            if (int'(bus.loss_count) !== exp_loss) begin
                errors++;
                $display("FAIL sat_count: loss %0d loss_count=%0d expected %0d", i + 1, bus.loss_count, exp_loss);
            end
            wait_release(1, idx);
            checks++;
            if (idx !== 13) begin
                errors++;
                $display("FAIL sat_release: loss %0d edge=%0d expected 13", i + 1, idx);
            end
        end
        checks++;
        if (bus.loss_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_final: loss_count=%0d expected 15", bus.loss_count);
        end
        $display("test_saturation: 17 losses, loss_count %0d", bus.loss_count);
    endtask

    task automatic test_async_reset();
        int idx;
        bus.pll_locked = 1'b0;
        repeat (3) step();
        checks++;
        if (bus.state_o !== 3'd4) begin
            errors++;
            $display("FAIL async_pre_hold: state_o=%0d expected 4", bus.state_o);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.esn_rst_n !== 1'b0 || bus.in_run !== 1'b0 || bus.lock_sync !== 1'b0 ||
            bus.state_o !== 3'd0 || bus.loss_count !== 4'd0) begin
            errors++;
            $display("FAIL async_hold: esn=%b in_run=%b lock_sync=%b state_o=%0d loss=%0d expected all 0",
                     bus.esn_rst_n, bus.in_run, bus.lock_sync, bus.state_o, bus.loss_count);
        end
        bus.pll_locked = 1'b1;
        @(negedge clock_50);
        reset_n = 1'b1;
        wait_release(0, idx);
        checks++;
        if (idx !== 10) begin
            errors++;
            $display("FAIL async_hold_restart: edge=%0d expected 10", idx);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.esn_rst_n !== 1'b0 || bus.in_run !== 1'b0 || bus.lock_sync !== 1'b0 ||
            bus.state_o !== 3'd0 || bus.loss_count !== 4'd0) begin
            errors++;
            $display("FAIL async_run: esn=%b in_run=%b lock_sync=%b state_o=%0d loss=%0d expected all 0",
                     bus.esn_rst_n, bus.in_run, bus.lock_sync, bus.state_o, bus.loss_count);
        end
        @(negedge clock_50);
        reset_n = 1'b1;
        wait_release(0, idx);
        checks++;
        if (idx !== 10) begin
            errors++;
            $display("FAIL async_run_restart: edge=%0d expected 10", idx);
        end
        $display("test_async_reset: restart edge %0d", idx);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.sw_rst_req = 1'b0;
        test_reset();
        test_stable_glitch();
        test_run_loss();
        test_sw_rst();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/esn_pll_reset_seq.md
Name: esn_pll_reset_seq

Overview:
Reset sequencer between the ESN system PLL and the ESN core reset input. It synchronises the PLL lock signal into the clock_50 domain and releases the active-low ESN reset only after lock has been continuously stable for a programmable number of cycles. On loss of lock it re-asserts the reset and holds it for a minimum time. It also counts lock-loss events. Its outputs drive the ESN external reset and the lock/status LEDs in the top-level system.

Parameters:
STABLE_CYCLES, 1024, number of consecutive synchronised-lock cycles required before reset release (≥2)
HOLD_CYCLES, 16, minimum cycles esn_rst_n stays low after entering HOLD (≥1)
CNT_W, 8, width of the saturating lock-loss counter

Ports:
clock_50  in  1  system clock; all logic on its rising edge
reset_n  in  1  asynchronous active-low reset for the block
pll_locked  in  1  raw PLL locked flag, asynchronous to clock_50
sw_rst_req  in  1  synchronous one-cycle request to re-reset the ESN core
esn_rst_n  out  1  active-low reset to the ESN core; registered
lock_sync  out  1  pll_locked after 2-flop synchroniser
in_run  out  1  high while state is RUN
state_o  out  3  state code: IDLE=0, WAIT_LOCK=1, STABLE=2, RUN=3, HOLD=4
loss_count  out  CNT_W  saturating count of RUN→HOLD transitions caused by lock loss

Behaviour:
- Reset (reset_n low, asynchronous): both synchroniser flops = 0, state = IDLE, counter = 0, esn_rst_n = 0, lock_sync = 0, in_run = 0, loss_count = 0, state_o = 0.
- Synchroniser: sync1 <= pll_locked; lock_sync <= sync1. No other logic samples pll_locked directly.
- One shared cycle counter, width clog2(max(STABLE_CYCLES, HOLD_CYCLES)).
- IDLE: advance to WAIT_LOCK unconditionally on the first edge after reset release.
- WAIT_LOCK: counter held at 0. If lock_sync = 1, go to STABLE with counter = 0.
- STABLE:
  - If lock_sync = 0, return to WAIT_LOCK and clear the counter. A single-cycle dropout fully restarts qualification. loss_count is not incremented.
  - Else, if counter = STABLE_CYCLES-1, go to RUN.
  - Else, increment the counter.
- RUN:
  - If lock_sync = 0, go to HOLD, clear the counter, and increment loss_count (saturating at all-ones).
  - Else, if sw_rst_req = 1, go to HOLD and clear the counter; loss_count is unchanged.
  - If both are true on the same cycle, treat it as a lock loss (loss_count increments).
- HOLD:
  - Ignores lock_sync and sw_rst_req.
  - Counter increments each cycle. When counter = HOLD_CYCLES-1, go to WAIT_LOCK.
- sw_rst_req is ignored in every state except RUN.
- Registered outputs:
  - esn_rst_n is 1 exactly when the registered state is RUN.
  - in_run equals esn_rst_n.
  - state_o is the state code.
  - All of these update on the same edge as the state register.
- Timing:
  - Label E0 as the first edge at which pll_locked is sampled high, with lock held high afterwards.
  - lock_sync goes high after E1. STABLE is entered at E2. RUN and esn_rst_n = 1 occur at E(STABLE_CYCLES+2).
  - Loss: pll_locked sampled low at E0 → esn_rst_n = 0 after E2.
  - HOLD is entered at Eh and left at Eh+HOLD_CYCLES. The earliest subsequent release is Eh+HOLD_CYCLES+1+STABLE_CYCLES.
- No combinational path from any input to any output.

Test Plan:
(Bench parameters: STABLE_CYCLES=8, HOLD_CYCLES=4, CNT_W=4.)
1. Assert reset_n=0 with pll_locked=1, then release. Check all outputs are 0 during reset. esn_rst_n rises 10 edges after the first post-reset sampling of pll_locked=1, and state_o then reads 3.
2. Lock glitch during STABLE: drop pll_locked for 1 cycle at STABLE count 5. Check state returns to 1 and esn_rst_n stays 0. Release is delayed to 10 edges after the restored lock, and loss_count stays 0.
3. Lock loss in RUN: drop pll_locked. Check esn_rst_n falls 2 edges later and loss_count = 1. HOLD (state_o=4) lasts exactly 4 cycles even if lock returns immediately. Re-release follows after WAIT_LOCK + 8 stable cycles.
4. sw_rst_req pulse in RUN: check HOLD for 4 cycles and loss_count unchanged. Repeat with sw_rst_req in STABLE and HOLD: check no effect. Then assert sw_rst_req on the same cycle lock_sync drops: check loss_count increments by 1.
5. Saturation: force 17 lock losses. Check loss_count stops at 15.
6. Assert reset_n mid-HOLD and mid-RUN, asynchronous to clock_50. Check all outputs go to 0 immediately, without waiting for a clock edge, and the full sequence restarts from IDLE after release.
